// File: rtl/hs_packet_demux_pkg.sv
// Shared definitions for the packet demux slice: width helper and FSM state encoding.
package hs_pkg;

    // Ceiling log2, never below 1 so a select field always has at least one bit.
    function automatic int log2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUTE = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

endpackage

// File: rtl/hs_packet_demux_if.sv
// Stream-side bundle of the 1:N packet demux: one input stream, N one-hot output ports.
interface hs_packet_demux_if
    import hs_pkg::*;
#(
    parameter int REQ_NUM = 8,
    parameter int DATA_WD = 8,
    parameter int CNT_WD  = 16
) ();
    localparam int DEST_WD = log2(REQ_NUM);

    // Handshake: a beat moves when valid and ready are both high at a rising clk edge;
    // a source holds valid and its data stable until that edge, and ready may not
    // depend combinationally on valid. Output port k transfers on valid_out[k] & ready_out[k].
    logic                 valid_in;
    logic [DATA_WD-1:0]   payload_in;
    logic                 last_in;
    logic [DEST_WD-1:0]   dest_in;
    logic                 ready_in;
    logic [REQ_NUM-1:0]   valid_out;
    logic [DATA_WD-1:0]   payload_out;
    logic                 last_out;
    logic [REQ_NUM-1:0]   ready_out;
    logic [CNT_WD-1:0]    drop_cnt;
    state_t               state;

    modport slave (
        input  valid_in, payload_in, last_in, dest_in, ready_out,
        output ready_in, valid_out, payload_out, last_out, drop_cnt, state
    );

    modport master (
        output valid_in, payload_in, last_in, dest_in, ready_out,
        input  ready_in, valid_out, payload_out, last_out, drop_cnt, state
    );

endinterface

// File: rtl/hs_packet_demux_skid_buffer.sv
// Two-entry valid/ready slice: head drives the consumer, skid absorbs one beat of backpressure.
module hs_skid_buffer #(
    parameter int WD = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push_valid,
    input  logic [WD-1:0] push_data,
    output logic          push_ready,
    output logic          head_valid,
    output logic [WD-1:0] head_data,
    input  logic          head_ready
);
    logic          skid_valid;
    logic [WD-1:0] skid_data;
    logic          pop;

    // Ready comes straight from a flop; the producer only pushes while the skid is empty.
    assign push_ready = !skid_valid;
    assign pop        = head_valid & head_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_valid <= 1'b0;
            head_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (pop) begin
            if (skid_valid) begin
                head_data  <= skid_data;
                skid_valid <= 1'b0;
            end else if (push_valid) begin
                head_data <= push_data;
            end else begin
                head_valid <= 1'b0;
            end
        end else if (push_valid) begin
            if (!head_valid) begin
                head_valid <= 1'b1;
                head_data  <= push_data;
            end else begin
                skid_valid <= 1'b1;
                skid_data  <= push_data;
            end
        end
    end

endmodule

// File: rtl/hs_packet_demux.sv
// 1:N packet router: locks a destination for a whole packet, buffers beats in a skid slice,
// and discards (and counts) packets addressed beyond the last port.
module hs_packet_demux
    import hs_pkg::*;
#(
    parameter int   REQ_NUM  = 8,
    parameter int   DATA_WD  = 8,
    parameter logic USE_LAST = 1'b1,
    parameter int   CNT_WD   = 16
) (
    input  logic              clk,
    input  logic              rstn,
    hs_packet_demux_if.slave  bus
);
    localparam int DEST_WD = log2(REQ_NUM);
    localparam int ENT_WD  = DATA_WD + 1 + DEST_WD;

    state_t               state;
    logic [DEST_WD-1:0]   sel;
    logic [CNT_WD-1:0]    drop_cnt;

    logic                 fire_in;
    logic                 in_range;
    logic                 pkt_open;
    logic                 push_valid;
    logic                 push_ready;
    logic [DEST_WD-1:0]   push_sel;
    logic [ENT_WD-1:0]    push_data;
    logic                 head_valid;
    logic                 head_ready;
    logic [ENT_WD-1:0]    head_data;
    logic [DEST_WD-1:0]   head_sel;

    assign in_range = 32'(bus.dest_in) < 32'(REQ_NUM);
    assign pkt_open = USE_LAST && !bus.last_in;

    // While discarding, beats are swallowed regardless of buffer occupancy.
    assign bus.ready_in = push_ready | (state == ST_DROP);
    assign fire_in      = bus.valid_in & bus.ready_in;

    assign push_sel   = (state == ST_ROUTE) ? sel : bus.dest_in;
    assign push_valid = fire_in & ((state == ST_ROUTE) | ((state == ST_IDLE) & in_range));
    assign push_data  = {bus.payload_in, bus.last_in, push_sel};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            sel      <= '0;
            drop_cnt <= '0;
        end else if (fire_in) begin
            case (state)
                ST_IDLE: begin
                    if (in_range) begin
                        sel <= bus.dest_in;
                        if (pkt_open) state <= ST_ROUTE;
                    end else begin
                        if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_WD'(1);
                        if (pkt_open) state <= ST_DROP;
                    end
                end
                ST_ROUTE, ST_DROP: begin
                    if (bus.last_in) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    hs_skid_buffer #(.WD(ENT_WD)) u_skid (
        .clk        (clk),
        .rstn       (rstn),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .head_valid (head_valid),
        .head_data  (head_data),
        .head_ready (head_ready)
    );

    // Each entry carries its own port select, so a new packet can follow a draining tail.
    assign head_sel        = head_data[DEST_WD-1:0];
    assign bus.last_out    = head_data[DEST_WD];
    assign bus.payload_out = head_data[ENT_WD-1 -: DATA_WD];
    assign bus.valid_out   = REQ_NUM'(head_valid) << head_sel;
    assign head_ready      = |(bus.valid_out & bus.ready_out);

    assign bus.drop_cnt = drop_cnt;
    assign bus.state    = state;

endmodule

// File: tb/tb_hs_packet_demux.sv
// Bench for hs_packet_demux: three instances (8 ports, 6 ports with a 2-bit drop counter, and
// single-beat mode) checked against a packet-level queue model every cycle plus directed steps.
module tb_hs_packet_demux;
    localparam int W = 14;  // {dut[1:0], port[2:0], last, data[7:0]}

    logic       clk;
    logic       rstn;
    logic [2:0] v_in;
    logic [2:0] l_in;
    logic [7:0] p_in [3];
    logic [2:0] d_in [3];
    logic [7:0] r_out [3];
    logic [2:0] rdy;
    logic [2:0] lout;
    logic [7:0] vout [3];
    logic [7:0] pout [3];
    logic [15:0] dcnt [3];

    int checks;
    int errors;
    int cyc;
    logic rand_done;

    logic [W-1:0] exp_q[$];
    logic [2:0]   in_pkt;
    logic [2:0]   cur_dest [3];
    int           drop_exp [3];

    hs_packet_demux_if #(.REQ_NUM(8), .DATA_WD(8), .CNT_WD(16)) if_a ();
    hs_packet_demux_if #(.REQ_NUM(6), .DATA_WD(8), .CNT_WD(2))  if_b ();
    hs_packet_demux_if #(.REQ_NUM(8), .DATA_WD(8), .CNT_WD(16)) if_c ();

    hs_packet_demux #(.REQ_NUM(8), .DATA_WD(8), .USE_LAST(1'b1), .CNT_WD(16)) dut_a (
        .clk(clk), .rstn(rstn), .bus(if_a));
    hs_packet_demux #(.REQ_NUM(6), .DATA_WD(8), .USE_LAST(1'b1), .CNT_WD(2)) dut_b (
        .clk(clk), .rstn(rstn), .bus(if_b));
    hs_packet_demux #(.REQ_NUM(8), .DATA_WD(8), .USE_LAST(1'b0), .CNT_WD(16)) dut_c (
        .clk(clk), .rstn(rstn), .bus(if_c));

    assign if_a.valid_in = v_in[0];  assign if_a.last_in = l_in[0];
    assign if_a.payload_in = p_in[0]; assign if_a.dest_in = d_in[0];
    assign if_a.ready_out = r_out[0];
    assign if_b.valid_in = v_in[1];  assign if_b.last_in = l_in[1];
    assign if_b.payload_in = p_in[1]; assign if_b.dest_in = d_in[1];
    assign if_b.ready_out = r_out[1][5:0];
    assign if_c.valid_in = v_in[2];  assign if_c.last_in = l_in[2];
    assign if_c.payload_in = p_in[2]; assign if_c.dest_in = d_in[2];
    assign if_c.ready_out = r_out[2];

    assign rdy  = {if_c.ready_in, if_b.ready_in, if_a.ready_in};
    assign lout = {if_c.last_out, if_b.last_out, if_a.last_out};
    assign vout[0] = if_a.valid_out;
    assign vout[1] = {2'b00, if_b.valid_out};
    assign vout[2] = if_c.valid_out;
    assign pout[0] = if_a.payload_out;
    assign pout[1] = if_b.payload_out;
    assign pout[2] = if_c.payload_out;
    assign dcnt[0] = if_a.drop_cnt;
    assign dcnt[1] = {14'd0, if_b.drop_cnt};
    assign dcnt[2] = if_c.drop_cnt;

    // Clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int nport(input int d);
        return (d == 1) ? 6 : 8;
    endfunction

    // Packet-level reference: one in-order queue of delivered beats per instance,
    // with the destination chosen on a packet's first beat.
    task automatic model_accept(input int d);
        logic [2:0] dest;
        dest = in_pkt[d] ? cur_dest[d] : d_in[d];
        if (int'(dest) < nport(d)) exp_q.push_back({2'(d), dest, l_in[d], p_in[d]});
        else if (!in_pkt[d] && drop_exp[d] < ((d == 1) ? 3 : 65535)) drop_exp[d]++;
        if (!in_pkt[d]) begin
            if (d != 2 && !l_in[d]) begin
                in_pkt[d]   = 1'b1;
                cur_dest[d] = d_in[d];
            end
        end else if (l_in[d]) begin
            in_pkt[d] = 1'b0;
        end
    endtask

    // Scoreboard: compare every output against the model head, then advance the model.
    always @(negedge clk) begin
        int occ;
        int fi;
        logic exp_rdy;
        for (int d = 0; d < 3; d++) begin
            if (!rstn) begin
                check("rst_valid_out", 32'(vout[d]), 0);
                check("rst_payload_out", 32'(pout[d]), 0);
                check("rst_last_out", 32'(lout[d]), 0);
                check("rst_drop_cnt", 32'(dcnt[d]), 0);
                check("rst_ready_in", 32'(rdy[d]), 1);
            end else begin
                occ = 0;
                fi  = -1;
                foreach (exp_q[i]) begin
                    if (int'(exp_q[i][13:12]) == d) begin
                        if (fi < 0) fi = i;
                        occ++;
                    end
                end
                exp_rdy = (occ < 2) || (in_pkt[d] && int'(cur_dest[d]) >= nport(d));
                check("ready_in", 32'(rdy[d]), 32'(exp_rdy));
                check("drop_cnt", 32'(dcnt[d]), 32'(drop_exp[d]));
                if (fi >= 0) begin
                    check("valid_out", 32'(vout[d]), 32'(8'd1 << exp_q[fi][11:9]));
                    check("payload_out", 32'(pout[d]), 32'(exp_q[fi][7:0]));
                    check("last_out", 32'(lout[d]), 32'(exp_q[fi][8]));
                    if (|(vout[d] & r_out[d])) exp_q.delete(fi);
                end else begin
                    check("valid_out_idle", 32'(vout[d]), 0);
                end
                if (v_in[d] && rdy[d]) model_accept(d);
            end
        end
        if (!rstn) begin
            exp_q.delete();
            in_pkt = 3'b000;
            for (int d = 0; d < 3; d++) drop_exp[d] = 0;
        end
    end

    // Driver tasks: called and returning at 1 time unit after a rising edge.
    task automatic send_beat(input int d, input logic [2:0] dest, input logic [7:0] data,
                             input logic last);
        int   n;
        logic accepted;
        n        = 0;
        accepted = 1'b0;
        v_in[d] = 1'b1;
        d_in[d] = dest;
        p_in[d] = data;
        l_in[d] = last;
        while (!accepted && n < 200) begin
            @(negedge clk);
            accepted = rdy[d];
            @(posedge clk);
            #1;
            n++;
        end
        check("beat_accepted", 32'(accepted), 1);
    endtask

    task automatic idle(input int d);
        v_in[d] = 1'b0;
    endtask

    task automatic rand_traffic(input int d);
        for (int p = 0; p < 30; p++) begin
            int len;
            logic [2:0] dest;
            len  = $urandom_range(1, 4);
            dest = 3'($urandom_range(0, 7));
            for (int b = 0; b < len; b++) begin
                send_beat(d, (b == 0) ? dest : 3'($urandom_range(0, 7)), 8'($urandom), b == len - 1);
                if ($urandom_range(0, 3) == 0) begin
                    idle(d);
                    @(posedge clk);
                    #1;
                end
            end
        end
        idle(d);
    endtask

    initial begin
        int c0;
        checks = 0;
        errors = 0;
        cyc    = 0;
        rand_done = 1'b0;
        in_pkt = 3'b000;
        rstn   = 1'b0;
        v_in   = 3'b000;
        l_in   = 3'b000;
        for (int d = 0; d < 3; d++) begin
            p_in[d] = '0;
            d_in[d] = '0;
            r_out[d] = 8'hff;
            cur_dest[d] = '0;
            drop_exp[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Routing: 4-beat packet to port 5, one beat out per cycle, one cycle after accept
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            send_beat(0, 3'd5, 8'(8'h10 + i), i == 3);
            check("t1_valid_out", 32'(vout[0]), 32'h20);
            check("t1_payload", 32'(pout[0]), 32'(8'h10 + i));
            check("t1_last", 32'(lout[0]), 32'(i == 3));
        end
        check("t1_throughput", 32'(cyc - c0), 4);
        idle(0);

        // Route lock: dest_in moves to 6 mid-packet, beats stay on port 2
        for (int i = 0; i < 4; i++) begin
            send_beat(0, (i < 2) ? 3'd2 : 3'd6, 8'(8'h20 + i), i == 3);
            check("t2_lock", 32'(vout[0]), 32'h04);
        end
        idle(0);
        @(posedge clk);
        #1;

        // Backpressure: port 3 stalled while a 6-beat packet arrives
        r_out[0] = 8'hf7;
        fork
            begin
                for (int i = 0; i < 6; i++) send_beat(0, 3'd3, 8'(8'h30 + i), i == 5);
                idle(0);
            end
            begin
                repeat (3) @(negedge clk);
                check("t3_ready_low", 32'(rdy[0]), 0);
                check("t3_held", 32'(vout[0]), 32'h08);
                repeat (2) @(negedge clk);
                @(posedge clk);
                #1;
                r_out[0] = 8'hff;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        check("t3_drained", 32'(vout[0]), 0);

        // Drop: 6-port instance, packet to 7 is swallowed, then a packet to 1 delivers
        for (int i = 0; i < 3; i++) begin
            send_beat(1, 3'd7, 8'(8'h70 + i), i == 2);
            check("t4_no_valid", 32'(vout[1]), 0);
        end
        idle(1);
        @(posedge clk);
        #1;
        check("t4_drop_cnt", 32'(dcnt[1]), 1);
        for (int i = 0; i < 2; i++) begin
            send_beat(1, 3'd1, 8'(8'h80 + i), i == 1);
            check("t4_deliver", 32'(vout[1]), 32'h02);
        end
        idle(1);

        // Single-beat mode: alternating destinations back-to-back
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            send_beat(2, (i % 2 == 0) ? 3'd0 : 3'd4, 8'(8'h90 + i), 1'b0);
            check("t5_valid_out", 32'(vout[2]), (i % 2 == 0) ? 32'h01 : 32'h10);
        end
        check("t5_throughput", 32'(cyc - c0), 4);
        idle(2);
        @(posedge clk);
        #1;

        // Reset in the middle of a packet, then a fresh packet to port 0
        send_beat(0, 3'd3, 8'h40, 1'b0);
        send_beat(0, 3'd3, 8'h41, 1'b0);
        rstn = 1'b0;
        idle(0);
        @(negedge clk);
        check("t6_rst_valid", 32'(vout[0]), 0);
        check("t6_rst_ready", 32'(rdy[0]), 1);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            send_beat(0, 3'd0, 8'(8'h50 + i), i == 1);
            check("t6_port0", 32'(vout[0]), 32'h01);
            check("t6_payload", 32'(pout[0]), 32'(8'h50 + i));
        end
        idle(0);
        check("t6_drop_a", 32'(dcnt[0]), 0);
        check("t6_drop_b", 32'(dcnt[1]), 0);

        // Random packets on all instances with random per-port backpressure
        fork
            begin
                fork
                    rand_traffic(0);
                    rand_traffic(1);
                    rand_traffic(2);
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    for (int d = 0; d < 3; d++) r_out[d] = 8'($urandom | $urandom);
                end
            end
        join
        for (int d = 0; d < 3; d++) r_out[d] = 8'hff;
        repeat (8) @(posedge clk);
        #1;
        check("drain_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
